// File: rtl/sw_job_scheduler_if.sv
// sw_job_scheduler_if: request/grant, array-controller and completion signals of sw_job_scheduler
interface sw_job_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int SCORE_W = 16
);
  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ-1:0] o_gnt;
  logic               o_start;
  logic               i_busy;
  logic [SCORE_W-1:0] i_result;
  logic               i_valid;
  logic               o_done;
  logic [ID_W-1:0]    o_done_id;
  logic [SCORE_W-1:0] o_score;
  logic               i_done_ready;
  logic               o_idle;
  logic               o_timeout;

  modport master (
    input  i_req, i_busy, i_result, i_valid, i_done_ready,
    output o_gnt, o_start, o_done, o_done_id, o_score, o_idle, o_timeout
  );

  modport slave (
    output i_req, i_busy, i_result, i_valid, i_done_ready,
    input  o_gnt, o_start, o_done, o_done_id, o_score, o_idle, o_timeout
  );
endinterface

// File: rtl/sw_job_scheduler.sv
// sw_job_scheduler: round-robin job scheduler for a shared PE array controller; watchdog enabled by SW_SCHED_WATCHDOG_EN
module sw_job_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int SCORE_W = 16,
  parameter int TIMEOUT = 1023
) (
  input logic clk,
  input logic rst_n,
  sw_job_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, RUN, RESP} state_t;
  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d, id_q, id_d, done_id_q, done_id_d, pick;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               start_q, start_d, done_q, done_d, idle_q, idle_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               found, wd_hit;

`ifdef SW_SCHED_WATCHDOG_EN
  localparam int WDG_W = $clog2(TIMEOUT + 1);
  logic [WDG_W-1:0] wdg_q, wdg_d;
  logic             timeout_q, timeout_d;
  // Watchdog: restart with each start pulse, count every cycle spent waiting on the array
  always_comb begin
    wdg_d = start_d ? '0 : (state_q == WAIT_BUSY || state_q == RUN) ? wdg_q + 1'b1 : wdg_q;
    wd_hit = (state_q == WAIT_BUSY || state_q == RUN) && !bus.i_valid && wdg_q == WDG_W'(TIMEOUT - 1);
    timeout_d = (state_d != RESP) ? 1'b0 : (state_q != RESP) ? wd_hit : timeout_q;
  end
  // Watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdg_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdg_q     <= wdg_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.o_timeout = timeout_q;
`else
  assign wd_hit        = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  // Round-robin pick: first active request at or above ptr, wrapping around
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.i_req[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        pick  = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Next state and registered outputs; a result or a watchdog expiry both complete the job
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = '0;
    start_d = 1'b0;
    score_d = score_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d[pick] = 1'b1;
          start_d     = 1'b1;
          id_d        = pick;
          ptr_d       = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
          state_d     = WAIT_BUSY;
        end
      end
      WAIT_BUSY, RUN: begin
        if (bus.i_valid || wd_hit) begin
          score_d = bus.i_valid ? bus.i_result : '0;
          state_d = RESP;
        end else if (state_q == WAIT_BUSY && bus.i_busy) begin
          state_d = RUN;
        end
      end
      RESP: state_d = bus.i_done_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    done_d    = (state_d == RESP);
    idle_d    = (state_d == IDLE);
    done_id_d = done_d ? id_q : done_id_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      gnt_q     <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      score_q   <= '0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      start_q   <= start_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      score_q   <= score_d;
      idle_q    <= idle_d;
    end
  end

  assign bus.o_gnt     = gnt_q;
  assign bus.o_start   = start_q;
  assign bus.o_done    = done_q;
  assign bus.o_done_id = done_id_q;
  assign bus.o_score   = score_q;
  assign bus.o_idle    = idle_q;
endmodule

// File: tb/tb_sw_job_scheduler.sv
// tb_sw_job_scheduler: directed self-checking bench for sw_job_scheduler
module tb_sw_job_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sw_job_scheduler_if #(.NUM_REQ(4), .ID_W(2), .SCORE_W(16)) bus ();

  sw_job_scheduler #(.NUM_REQ(4), .ID_W(2), .SCORE_W(16), .TIMEOUT(20)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string ctx);
    chk({ctx, " gnt"}, bus.o_gnt, 0);
    chk({ctx, " start"}, bus.o_start, 0);
    chk({ctx, " done"}, bus.o_done, 0);
    chk({ctx, " done_id"}, bus.o_done_id, 0);
    chk({ctx, " score"}, bus.o_score, 0);
    chk({ctx, " timeout"}, bus.o_timeout, 0);
    chk({ctx, " idle"}, bus.o_idle, 1);
  endtask

  task automatic job(input logic [3:0] req, input int id, input logic [15:0] res);
    bus.i_req = req;
    tick();
    chk("job gnt", bus.o_gnt, 32'(1 << id));
    chk("job start", bus.o_start, 1);
    chk("job idle", bus.o_idle, 0);
    bus.i_busy = 1'b1;
    tick();
    chk("job start pulse", bus.o_start, 0);
    chk("job gnt pulse", bus.o_gnt, 0);
    bus.i_busy  = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_result = res;
    tick();
    chk("job done", bus.o_done, 1);
    chk("job done_id", bus.o_done_id, id);
    chk("job score", bus.o_score, res);
    bus.i_valid = 1'b0;
    bus.i_done_ready = 1'b1;
    tick();
    chk("job release done", bus.o_done, 0);
    chk("job release idle", bus.o_idle, 1);
    chk("job release gnt", bus.o_gnt, 0);
    bus.i_done_ready = 1'b0;
  endtask

  initial begin
    bus.i_req = '0;
    bus.i_busy = 1'b0;
    bus.i_result = '0;
    bus.i_valid = 1'b0;
    bus.i_done_ready = 1'b0;
    #12;
    chk_reset("reset");
    rst_n = 1'b1;
    tick();
    // stray result while idle is ignored
    bus.i_valid = 1'b1;
    bus.i_result = 16'd555;
    tick();
    chk("idle valid done", bus.o_done, 0);
    chk("idle valid score", bus.o_score, 0);
    chk("idle valid idle", bus.o_idle, 1);
    bus.i_valid = 1'b0;
    // single job for requester 2
    bus.i_req = 4'b0100;
    tick();
    chk("single gnt", bus.o_gnt, 4'b0100);
    chk("single start", bus.o_start, 1);
    bus.i_req = '0;
    tick();
    chk("single start pulse", bus.o_start, 0);
    bus.i_busy = 1'b1;
    tick();
    bus.i_busy = 1'b0;
    tick();
    tick();
    chk("busy drop no done", bus.o_done, 0);
    bus.i_valid = 1'b1;
    bus.i_result = 16'd37;
    tick();
    bus.i_valid = 1'b0;
    chk("single done", bus.o_done, 1);
    chk("single done_id", bus.o_done_id, 2);
    chk("single score", bus.o_score, 37);
    // backpressure with a pending request
    bus.i_req = 4'b1001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp done", bus.o_done, 1);
      chk("bp done_id", bus.o_done_id, 2);
      chk("bp score", bus.o_score, 37);
      chk("bp start", bus.o_start, 0);
    end
    bus.i_done_ready = 1'b1;
    tick();
    bus.i_done_ready = 1'b0;
    chk("accept done", bus.o_done, 0);
    chk("accept no gnt", bus.o_gnt, 0);
    chk("accept score kept", bus.o_score, 37);
    // wrap from ptr 3
    job(4'b1001, 3, 16'd11);
    job(4'b1001, 0, 16'd12);
    // result arriving before busy completes from WAIT_BUSY
    bus.i_req = 4'b0010;
    tick();
    chk("direct gnt", bus.o_gnt, 4'b0010);
    bus.i_req = '0;
    bus.i_valid = 1'b1;
    bus.i_result = 16'd99;
    tick();
    bus.i_valid = 1'b0;
    chk("direct done", bus.o_done, 1);
    chk("direct done_id", bus.o_done_id, 1);
    chk("direct score", bus.o_score, 99);
    bus.i_done_ready = 1'b1;
    tick();
    bus.i_done_ready = 1'b0;
    // reset during RUN
    bus.i_req = 4'b0100;
    tick();
    chk("pre-reset gnt", bus.o_gnt, 4'b0100);
    bus.i_req = '0;
    bus.i_busy = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1 chk_reset("async reset");
    bus.i_busy = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    chk("post-reset done", bus.o_done, 0);
    chk("post-reset idle", bus.o_idle, 1);
    // fairness from ptr 0
    for (int i = 0; i < 8; i++) job(4'b1111, i % 4, 16'(100 + i));
    bus.i_req = '0;
    tick();
    // result never arrives
    bus.i_req = 4'b0001;
    tick();
    chk("wd gnt", bus.o_gnt, 4'b0001);
    chk("wd start", bus.o_start, 1);
    bus.i_req = '0;
`ifdef SW_SCHED_WATCHDOG_EN
    for (int i = 0; i < 19; i++) tick();
    chk("wd early done", bus.o_done, 0);
    tick();
    chk("wd done", bus.o_done, 1);
    chk("wd timeout", bus.o_timeout, 1);
    chk("wd score", bus.o_score, 0);
    chk("wd done_id", bus.o_done_id, 0);
    bus.i_done_ready = 1'b1;
    tick();
    bus.i_done_ready = 1'b0;
    chk("wd timeout clear", bus.o_timeout, 0);
    chk("wd idle", bus.o_idle, 1);
`else
    for (int i = 0; i < 2000; i++) tick();
    chk("no wd done", bus.o_done, 0);
    chk("no wd idle", bus.o_idle, 0);
    chk("no wd timeout", bus.o_timeout, 0);
    bus.i_valid = 1'b1;
    bus.i_result = 16'd7;
    tick();
    bus.i_valid = 1'b0;
    chk("late done", bus.o_done, 1);
    chk("late score", bus.o_score, 7);
    bus.i_done_ready = 1'b1;
    tick();
    bus.i_done_ready = 1'b0;
    chk("late idle", bus.o_idle, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
